// File: rtl/rom_dl_sequencer_pkg.sv
// Purpose : shared constants and types for the ROM download sequencer and the ROM bank decoders.
// Latency : n/a (package only).
// Backpressure: n/a; the download stream is never stalled.
// Contents: FSM state enum, ROM map region bases, last valid byte address, saturating counter helper.
package rom_dl_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } dl_state_t;

  // ROM map region bases (byte addresses in the 18-bit ROM space).
  localparam logic [17:0] MAIN_BASE = 18'h00000;
  localparam logic [17:0] SUB_BASE  = 18'h08000;
  localparam logic [17:0] BGCH_BASE = 18'h0E000;
  localparam logic [17:0] SPCH_BASE = 18'h10000;
  localparam logic [17:0] CLUT_BASE = 18'h20000;
  localparam logic [17:0] PAL_BASE  = 18'h20500;
  localparam logic [17:0] MAX_AD    = 18'h207FF;

  // Byte counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [17:0] sat_inc18(input logic [17:0] v);
    return (v == 18'h3FFFF) ? v : v + 18'd1;
  endfunction

endpackage

// File: rtl/rom_dl_hold_timer.sv
// Purpose : loadable down-counter that times the post-download reset hold.
// Latency : load takes effect at the next edge; tc is a decode of the count flop.
// Backpressure: none; dec below zero is ignored so the count rests at 0.
// Ports   : clk, reset (async, active-high), load/load_val, dec -> tc (count == 0).
module rom_dl_hold_timer #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          tc
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/rom_dl_sequencer.sv
// Purpose : sequences the HPS byte-stream download into the shared ROM write port and gates CPU reset.
// Latency : one clk from dl_wr to ROMEN/ROMAD/ROMDT; all outputs are flops.
// Backpressure: none; a dl_wr every cycle is accepted without stall.
// Ports   : clk, reset (async, active-high); dl_en/dl_wr/dl_addr/dl_data from HPS;
//           ROMAD/ROMDT/ROMEN shared ROM write port; core_reset, ld_done, oor, bytes, csum status.
module rom_dl_sequencer #(
  parameter logic [17:0] MAX_AD   = rom_dl_sequencer_pkg::MAX_AD,
  parameter int          HOLD_CYC = 16,
  parameter int          CW       = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dl_en,
  input  logic        dl_wr,
  input  logic [24:0] dl_addr,
  input  logic [7:0]  dl_data,
  output logic [17:0] ROMAD,
  output logic [7:0]  ROMDT,
  output logic        ROMEN,
  output logic        core_reset,
  output logic        ld_done,
  output logic        oor,
  output logic [17:0] bytes,
  output logic [15:0] csum
);

  import rom_dl_sequencer_pkg::*;

  dl_state_t state;
  logic      addr_ok;
  logic      hold_load;
  logic      hold_dec;
  logic      hold_tc;

  // Full 25-bit compare so any upper bit [24:18] set counts as out of range.
  assign addr_ok = (dl_addr <= {7'd0, MAX_AD});

  // Timer is armed on the LOAD->HOLD edge, so HOLD lasts exactly HOLD_CYC cycles.
  assign hold_load = (state == ST_LOAD) && !dl_en;
  assign hold_dec  = (state == ST_HOLD);

  rom_dl_hold_timer #(
    .CW (CW)
  ) u_hold_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (hold_load),
    .load_val (CW'(HOLD_CYC - 1)),
    .dec      (hold_dec),
    .tc       (hold_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      ROMAD      <= '0;
      ROMDT      <= '0;
      ROMEN      <= 1'b0;
      core_reset <= 1'b1;
      ld_done    <= 1'b0;
      oor        <= 1'b0;
      bytes      <= '0;
      csum       <= '0;
    end else begin
      ROMEN <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (dl_en) begin
            state <= ST_LOAD;
            bytes <= '0;
            csum  <= '0;
            oor   <= 1'b0;
          end
        end

        ST_LOAD: begin
          // A strobe arriving with the falling dl_en is still taken: FSM is in LOAD.
          if (dl_wr) begin
            if (addr_ok) begin
              ROMEN <= 1'b1;
              ROMAD <= dl_addr[17:0];
              ROMDT <= dl_data;
              bytes <= sat_inc18(bytes);
              csum  <= csum + {8'd0, dl_data};
            end else begin
              oor <= 1'b1;
            end
          end
          if (!dl_en) begin
            state <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          if (dl_en) begin
            // Re-download before the hold expired; the timer is simply left behind.
            state <= ST_LOAD;
            bytes <= '0;
            csum  <= '0;
            oor   <= 1'b0;
          end else if (hold_tc) begin
            state      <= ST_RUN;
            core_reset <= 1'b0;
            ld_done    <= 1'b1;
          end
        end

        ST_RUN: begin
          if (dl_en) begin
            state      <= ST_LOAD;
            core_reset <= 1'b1;
            ld_done    <= 1'b0;
            bytes      <= '0;
            csum       <= '0;
            oor        <= 1'b0;
          end
        end

        default: begin
          state      <= ST_IDLE;
          core_reset <= 1'b1;
          ld_done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
